// File: rtl/sonar_pkg.sv
// Shared types and default timing for the ultrasonic ranging sequencer.
// Cycle defaults are derived from the 50 MHz system clock.
package sonar_pkg;

  localparam int unsigned SONAR_CLK_HZ        = 50_000_000;
  localparam int unsigned SONAR_TRIG_CYC      = SONAR_CLK_HZ / 100_000;  // 10 us
  localparam int unsigned SONAR_ECHO_WAIT_CYC = SONAR_CLK_HZ / 500;      // 2 ms
  localparam int unsigned SONAR_GUARD_CYC     = SONAR_CLK_HZ / 20;       // 50 ms

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_GUARD
  } sonar_seq_state_t;

endpackage

// File: rtl/cyc_timer.sv
// Loadable up-counter: restarts at zero on load, holds at limit, and flags
// expired while the count equals the limit.
module cyc_timer #(
  parameter int unsigned CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count != limit) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/sonar_trigger_seq.sv
// Ultrasonic measurement sequencer: trigger pulse, echo supervision,
// bounded retries, inter-measurement guard and continuous ranging.
module sonar_trigger_seq
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYC      = SONAR_TRIG_CYC,
  parameter int unsigned ECHO_WAIT_CYC = SONAR_ECHO_WAIT_CYC,
  parameter int unsigned GUARD_CYC     = SONAR_GUARD_CYC,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 22
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           cont,
  input  logic                           trig_suc,
  input  logic                           meas_valid,
  input  logic                           meas_fail,
  output logic                           trigger,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [$clog2(MAX_RETRY+1)-1:0] attempt
);

  localparam int unsigned AW = $clog2(MAX_RETRY + 1);

  // The timer restarts at 0 on entry, so each limit is the last count value
  // before leaving; GUARD holds one extra decision cycle after GUARD_CYC.
  localparam logic [CNT_W-1:0] TRIG_LIM  = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_LIM  = CNT_W'(ECHO_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYC);

  sonar_seq_state_t state_q, state_d;
  logic             latch_q, latch_d;
  logic             failed_q, failed_d;
  logic [AW-1:0]    attempt_d;
  logic             done_d, timeout_d;
  logic             timer_load, timer_exp;
  logic [CNT_W-1:0] timer_limit;

  cyc_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .limit   (timer_limit),
    .expired (timer_exp)
  );

  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q;
    failed_d  = failed_q;
    attempt_d = attempt;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start || cont) begin
          state_d   = S_TRIG;
          attempt_d = '0;
          latch_d   = 1'b0;
        end
      end
      S_TRIG: begin
        if (trig_suc) latch_d = 1'b1;
        if (timer_exp) state_d = (latch_q || trig_suc) ? S_MEASURE : S_WAIT_ECHO;
      end
      S_WAIT_ECHO: begin
        if (trig_suc) begin
          state_d = S_MEASURE;
        end else if (timer_exp) begin
          state_d  = S_GUARD;
          failed_d = 1'b1;
        end
      end
      S_MEASURE: begin
        if (meas_valid) begin
          state_d  = S_GUARD;
          failed_d = 1'b0;
          done_d   = 1'b1;
        end else if (meas_fail) begin
          state_d  = S_GUARD;
          failed_d = 1'b1;
        end
      end
      S_GUARD: begin
        if (timer_exp) begin
          if (failed_q) begin
            if (attempt == AW'(MAX_RETRY)) begin
              state_d   = S_IDLE;
              timeout_d = 1'b1;
            end else begin
              state_d   = S_TRIG;
              attempt_d = attempt + AW'(1);
              latch_d   = 1'b0;
            end
          end else if (cont) begin
            state_d   = S_TRIG;
            attempt_d = '0;
            latch_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_q)
      S_TRIG:      timer_limit = TRIG_LIM;
      S_WAIT_ECHO: timer_limit = ECHO_LIM;
      S_GUARD:     timer_limit = GUARD_LIM;
      default:     timer_limit = '0;
    endcase
    timer_load = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      latch_q  <= 1'b0;
      failed_q <= 1'b0;
      attempt  <= '0;
      trigger  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      failed_q <= failed_d;
      attempt  <= attempt_d;
      trigger  <= (state_d == S_TRIG);
      busy     <= (state_d != S_IDLE);
      done     <= done_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sonar_trigger_seq.sv
// Directed and randomized checks of sonar_trigger_seq against an event-time
// model computed from the sequencing rules.
module tb_sonar_trigger_seq;

  localparam int TRIG  = 5;
  localparam int ECHO  = 20;
  localparam int GUARD = 30;
  localparam int MAXR  = 2;

  typedef enum int {K_NOECHO, K_FAIL, K_OK, K_BOTH, K_EARLY} kind_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, cont = 1'b0, trig_suc = 1'b0;
  logic       meas_valid = 1'b0, meas_fail = 1'b0;
  logic       trigger, busy, done, timeout;
  logic [1:0] attempt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int mon_rise[$], mon_ratt[$], mon_fall[$], mon_done[$], mon_datt[$], mon_to[$], mon_bfall[$];
  logic p_trig = 1'b0, p_busy = 1'b0;

  kind_t p_kind[3];
  int    p_d[3], p_m[3];

  sonar_trigger_seq #(
    .TRIG_CYC      (TRIG),
    .ECHO_WAIT_CYC (ECHO),
    .GUARD_CYC     (GUARD),
    .MAX_RETRY     (MAXR),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .trig_suc   (trig_suc),
    .meas_valid (meas_valid),
    .meas_fail  (meas_fail),
    .trigger    (trigger),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .attempt    (attempt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trigger && !p_trig) begin
      mon_rise.push_back(cyc);
      mon_ratt.push_back(int'(attempt));
    end
    if (!trigger && p_trig) mon_fall.push_back(cyc);
    if (done) begin
      mon_done.push_back(cyc);
      mon_datt.push_back(int'(attempt));
    end
    if (timeout) mon_to.push_back(cyc);
    if (!busy && p_busy) mon_bfall.push_back(cyc);
    p_trig <= trigger;
    p_busy <= busy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    chk($sformatf("%s.count", tag), got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic clear_mon();
    mon_rise.delete(); mon_ratt.delete(); mon_fall.delete();
    mon_done.delete(); mon_datt.delete(); mon_to.delete(); mon_bfall.delete();
  endtask

  // One clock; single-cycle strobes set before a step end after it.
  task automatic step();
    @(negedge clk);
    start = 1'b0; trig_suc = 1'b0; meas_valid = 1'b0; meas_fail = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic set_plan(input int i, input kind_t k, input int d, input int m);
    p_kind[i] = k; p_d[i] = d; p_m[i] = m;
  endtask

  task automatic run_seq(input string name, input bit use_cont, input int n_plan, input int drop);
    int e_rise[$], e_ratt[$], e_fall[$], e_done[$], e_datt[$], e_to[$], e_bf[$];
    int t, f, g, att, n_exp, r, f2, mt;
    bit stop, ok;
    clear_mon();
    t = cyc + 1; att = 0; n_exp = 0; stop = 0;
    for (int i = 0; i < n_plan && !stop; i++) begin
      e_rise.push_back(t); e_ratt.push_back(att); n_exp++;
      f = t + TRIG;
      e_fall.push_back(f);
      case (p_kind[i])
        K_NOECHO: begin g = f + ECHO; ok = 0; end
        K_FAIL:   begin g = f + p_d[i] + p_m[i]; ok = 0; end
        K_EARLY:  begin g = f + p_m[i]; ok = 1; end
        default:  begin g = f + p_d[i] + p_m[i]; ok = 1; end
      endcase
      if (ok) begin e_done.push_back(g); e_datt.push_back(att); end
      t = g + GUARD + 1;
      if (!ok && att == MAXR) begin e_to.push_back(t); stop = 1; end
      else if (!ok) att++;
      else if (use_cont && i < drop) att = 0;
      else stop = 1;
    end
    e_bf.push_back(t);

    if (use_cont) cont = 1'b1; else start = 1'b1;
    step();
    for (int i = 0; i < n_exp; i++) begin
      for (int k = 0; k < 400 && !trigger; k++) step();
      if (!trigger) begin chk($sformatf("%s.rise_seen%0d", name, i), int'(trigger), 1); break; end
      r = cyc;
      if (p_kind[i] == K_EARLY) begin wait_to(r + 1); trig_suc = 1'b1; step(); end
      for (int k = 0; k < 400 && trigger; k++) step();
      if (trigger) begin chk($sformatf("%s.fall_seen%0d", name, i), int'(trigger), 0); break; end
      f2 = cyc;
      start = 1'b1;  // busy: must be ignored
      if (p_kind[i] == K_NOECHO) meas_valid = 1'b1;  // stray in WAIT_ECHO
      if (p_kind[i] != K_NOECHO) begin
        if (p_kind[i] == K_EARLY) mt = f2 + p_m[i];
        else begin
          wait_to(f2 + p_d[i] - 1);
          trig_suc = 1'b1;
          mt = f2 + p_d[i] + p_m[i];
        end
        wait_to(mt - 1);
        meas_valid = (p_kind[i] != K_FAIL);
        meas_fail  = (p_kind[i] == K_FAIL || p_kind[i] == K_BOTH);
        if (use_cont && i == drop) cont = 1'b0;
      end
      step();
    end
    for (int k = 0; k < 400 && busy; k++) step();
    chk($sformatf("%s.busy_released", name), int'(busy), 0);
    cont = 1'b0;
    repeat (5) step();

    cmp_q({name, ".rise"}, mon_rise, e_rise);
    cmp_q({name, ".rise_att"}, mon_ratt, e_ratt);
    cmp_q({name, ".fall"}, mon_fall, e_fall);
    cmp_q({name, ".done"}, mon_done, e_done);
    cmp_q({name, ".done_att"}, mon_datt, e_datt);
    cmp_q({name, ".timeout"}, mon_to, e_to);
    cmp_q({name, ".busy_fall"}, mon_bfall, e_bf);
  endtask

  task automatic reset_now(input string name);
    #2 rst_n = 1'b0;
    #1;
    chk({name, ".trigger"}, int'(trigger), 0);
    chk({name, ".busy"}, int'(busy), 0);
    chk({name, ".done"}, int'(done), 0);
    chk({name, ".timeout"}, int'(timeout), 0);
    chk({name, ".attempt"}, int'(attempt), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    clear_mon();
    repeat (80) step();
    chk({name, ".quiet_rises"}, mon_rise.size(), 0);
    chk({name, ".quiet_done"}, mon_done.size(), 0);
    chk({name, ".quiet_timeout"}, mon_to.size(), 0);
    chk({name, ".quiet_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset.trigger", int'(trigger), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.timeout", int'(timeout), 0);
    chk("reset.attempt", int'(attempt), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    set_plan(0, K_OK, 3, 40);
    run_seq("single", 0, 1, -1);

    set_plan(0, K_NOECHO, 0, 0); set_plan(1, K_NOECHO, 0, 0); set_plan(2, K_NOECHO, 0, 0);
    run_seq("noecho", 0, 3, -1);

    set_plan(0, K_FAIL, $urandom_range(1, 19), $urandom_range(1, 50));
    set_plan(1, K_OK, $urandom_range(1, 19), $urandom_range(1, 50));
    run_seq("recovery", 0, 2, -1);

    for (int i = 0; i < 3; i++) set_plan(i, K_OK, $urandom_range(1, 19), $urandom_range(1, 50));
    run_seq("cont", 1, 3, 2);

    set_plan(0, K_EARLY, 0, $urandom_range(1, 30));
    run_seq("early", 0, 1, -1);
    set_plan(0, K_BOTH, $urandom_range(1, 19), $urandom_range(1, 30));
    run_seq("both", 0, 1, -1);

    meas_valid = 1'b1; meas_fail = 1'b1; trig_suc = 1'b1;
    step();
    clear_mon();
    repeat (20) step();
    chk("stray.busy", int'(busy), 0);
    chk("stray.rises", mon_rise.size(), 0);
    chk("stray.done", mon_done.size(), 0);

    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 3; i++)
        set_plan(i, kind_t'($urandom_range(0, 4)), $urandom_range(1, 19), $urandom_range(1, 50));
      run_seq($sformatf("rand%0d", s), 0, 3, -1);
    end

    start = 1'b1;
    step();
    for (int k = 0; k < 20 && !trigger; k++) step();
    chk("rst_trig.in_trig", int'(trigger), 1);
    step(); step();
    reset_now("rst_trig");

    start = 1'b1;
    step();
    for (int k = 0; k < 20 && !trigger; k++) step();
    for (int k = 0; k < 20 && trigger; k++) step();
    for (int k = 0; k < 100 && !trigger; k++) step();
    for (int k = 0; k < 20 && trigger; k++) step();
    wait_to(cyc + 25);
    chk("rst_guard.pre_attempt", int'(attempt), 1);
    chk("rst_guard.pre_busy", int'(busy), 1);
    reset_now("rst_guard");

    set_plan(0, K_OK, 3, 40);
    run_seq("after_reset", 0, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sonar_trigger_seq.md
# sonar_trigger_seq

Measurement sequencer that sits directly upstream of the ultrasonic echo-timing stage. It generates the sensor trigger pulse, watches that stage's `triggerSuc`/`valid`/`fail` strobes, and enforces the inter-measurement guard interval (50 ms at 50 MHz) against acoustic interference. It retries failed attempts a bounded number of times and supports single-shot or continuous ranging. Its per-measurement status flows to the application layer.

## Interface
- `TRIG_CYC`, 500: trigger high time in cycles (10 µs @ 50 MHz).
- `ECHO_WAIT_CYC`, 100_000: max cycles from trigger fall to `trig_suc` (2 ms).
- `GUARD_CYC`, 2_500_000: post-attempt quiet time in cycles (50 ms).
- `MAX_RETRY`, 3: retries after a failed attempt (attempts total = MAX_RETRY+1).
- `CNT_W`, 22: timer width; must hold max(TRIG_CYC, ECHO_WAIT_CYC, GUARD_CYC).
- `clk  in  1`: system clock, 50 MHz.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: single-shot request, sampled only in IDLE.
- `cont  in  1`: continuous-mode level; while high, the next measurement starts after each guard.
- `trig_suc  in  1`: one-cycle strobe from the echo stage (echo rose).
- `meas_valid  in  1`: one-cycle strobe; distance is valid in the echo stage.
- `meas_fail  in  1`: one-cycle strobe; echo stage counter overflowed.
- `trigger  out  1`: sensor trigger pin.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse on a successful measurement.
- `timeout  out  1`: one-cycle pulse when all attempts have failed.
- `attempt  out  $clog2(MAX_RETRY+1)`: index of the current attempt (0 = first).

## Operation
- FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, GUARD. All outputs are registered.
- **IDLE**
  - `start` or `cont` high → TRIG, `attempt`=0.
- **TRIG**
  - `trigger`=1 for exactly TRIG_CYC cycles.
  - If `trig_suc` arrives during TRIG, it is latched. At trigger fall the FSM goes to MEASURE if latched, otherwise WAIT_ECHO.
- **WAIT_ECHO**
  - `trig_suc` → MEASURE.
  - After ECHO_WAIT_CYC cycles without `trig_suc` → failed attempt → GUARD.
- **MEASURE**
  - `meas_valid` → `done` pulse → GUARD (success).
  - `meas_fail` → failed attempt → GUARD.
  - If both strobes arrive in the same cycle, `meas_valid` wins.
  - No local timeout here; the echo stage guarantees one of the two strobes.
- **GUARD**
  - Counts GUARD_CYC cycles, then:
    - failed and `attempt` < MAX_RETRY → `attempt`+1, go to TRIG;
    - failed and `attempt` == MAX_RETRY → `timeout` pulse, go to IDLE;
    - success and `cont` high → `attempt`=0, go to TRIG;
    - success and `cont` low → IDLE.
- Strobes are ignored outside the states that consume them: `trig_suc` outside TRIG/WAIT_ECHO, `meas_*` outside MEASURE.
- `start` while `busy` is ignored, not queued.
- Dropping `cont` mid-sequence finishes the current measurement, including retries and guard, then goes to IDLE.
- One shared timer is reloaded on every state entry. Compare is ==; the timer never wraps.

## Timing
- Reset values: state IDLE; `trigger`, `busy`, `done`, `timeout` = 0; `attempt` = 0; timer = 0; latch = 0.
- `start` sampled high at edge N → `trigger` and `busy` high from N+1 for exactly TRIG_CYC cycles.
- `done` is high in the cycle after `meas_valid` is sampled. GUARD starts that same cycle.
- Failed attempt to next trigger: exactly GUARD_CYC cycles of `trigger`=0 after the fail is detected, then +1 cycle.
- `timeout` is asserted in the cycle `busy` falls.
- Reset mid-operation:
  - `trigger` drops asynchronously;
  - no `done`/`timeout` is emitted;
  - the next sequence requires a fresh `start`/`cont`.

## Structure
- Shared package `sonar_pkg`:
  - state enum `sonar_seq_state_t`;
  - default cycle constants (`SONAR_TRIG_CYC`, `SONAR_GUARD_CYC`, `SONAR_ECHO_WAIT_CYC`);
  - `SONAR_CLK_HZ` = 50_000_000.
- One sub-module, `cyc_timer`: a loadable up-counter with `load`, `limit`, and an `expired` flag, parameterised by CNT_W.

## Test plan
Bench parameters: TRIG_CYC=5, ECHO_WAIT_CYC=20, GUARD_CYC=30, MAX_RETRY=2.
- Single shot: `start` pulse, `trig_suc` 3 cycles after trigger fall, `meas_valid` 40 cycles later → trigger high exactly 5 cycles; `done` 1 cycle after `meas_valid`; `busy` low 31 cycles after `done`; `attempt`=0.
- No echo at all: `start` only → 3 triggers each 5 cycles; successive triggers separated by 20+30+1 cycles; `attempt` 0→1→2; single `timeout` pulse; IDLE.
- Recovery: `meas_fail` on attempt 0, `meas_valid` on attempt 1 → one `done`, no `timeout`, `attempt`=1 at `done`.
- Continuous: `cont` held with 3 successful echoes, then `cont` dropped during the 3rd MEASURE → 3 `done` pulses; trigger rising edges spaced by measurement+31 cycles; IDLE after the 3rd guard.
- Edge cases:
  - `trig_suc` during TRIG → MEASURE at trigger fall;
  - `start` while busy → ignored;
  - `meas_valid` and `meas_fail` together → `done` only;
  - stray `meas_valid` in IDLE → no response.
- `rst_n` low mid-TRIG and mid-GUARD → all outputs 0 immediately; no pulses after release; a new `start` behaves as the single-shot case.
